alu_writeback: RTL and testbench
================================

# alu_writeback

Execute-to-writeback sequencer at the consuming end of the ALU result interface. It captures each ALU result (primary result, R0 side result, overflow) with a valid/ready handshake and serialises it onto the single register-file write port. MUL and DIV produce two results (dest plus R0), so they take two write cycles. On a signed-overflow ADD/SUB it raises a trap request to the control unit, held until acknowledged.

## Interface
- DATA_W, 16, datapath width
- REG_AW, 4, register address width
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- ex_valid  in  1  execute stage offers a result
- ex_ready  out  1  block accepts the offer this cycle
- ex_ctrl  in  4  ALU control code of the op
- ex_wb_en  in  1  op writes the register file
- ex_rd  in  REG_AW  destination register
- ex_result  in  DATA_W  ALU primary result (low product / quotient)
- ex_r0  in  DATA_W  ALU side result (high product / remainder)
- ex_overflow  in  1  ALU overflow flag
- ex_pc  in  DATA_W  PC of the op
- rf_we  out  1  register-file write enable
- rf_waddr  out  REG_AW  write address
- rf_wdata  out  DATA_W  write data
- exc_req  out  1  overflow trap pending
- exc_epc  out  DATA_W  PC of the trapping op
- exc_ack  in  1  control unit accepts trap

## Operation
- Ctrl codes (shared package): ADD 1, SUB 2, MUL 4, DIV 8, ANDI C, ORI E, ADDNF F. Any other code is a no-write op.
- Accept = ex_valid & ex_ready. Accepted fields are captured into holding registers. Outputs are driven only from state and holding registers, with no combinational path from ex_* to rf_*/exc_*.
- FSM states: IDLE, WR_RD, WR_R0, EXC.
- Next state on accept, from IDLE, WR_RD or WR_R0:
  - ex_overflow & ctrl in {ADD, SUB}: go to EXC. Nothing is written.
  - Else ctrl in {MUL, DIV} & wb_en: go to WR_RD, then WR_R0.
  - Else valid code & wb_en: go to WR_RD.
  - Else: op is dropped; go to IDLE.
- With no accept: WR_RD goes to WR_R0 for MUL/DIV, otherwise to IDLE. WR_R0 goes to IDLE. EXC holds until exc_ack, then goes to IDLE.
- WR_RD: rf_we=1, rf_waddr=rd, rf_wdata=result.
  - Exception: MUL/DIV with rd=0 suppresses rf_we in WR_RD, so R0 receives only the side result.
- WR_R0: rf_we=1, rf_waddr=0, rf_wdata=r0.
- ex_ready:
  - 0 while rst is high.
  - 0 in WR_RD of a MUL/DIV op.
  - 0 in EXC.
  - 1 otherwise.
- exc_ack is ignored outside EXC.

## Timing
- Op accepted at edge N is written during cycle N+1. The R0 write of MUL/DIV occurs in cycle N+2.
- Throughput: single-write ops sustain one per cycle. MUL/DIV sustain one per two cycles. A new op may be accepted during WR_R0.
- Trap: exc_req rises in cycle N+1 and exc_epc is stable while exc_req=1. On exc_ack in cycle M, exc_req=0 in cycle M+1 and ex_ready=1 in cycle M+1.
- Reset values: state IDLE, rf_we 0, rf_waddr 0, rf_wdata 0, exc_req 0, exc_epc 0, holding registers 0.
- Reset asserted mid-MUL/DIV aborts the sequence. The pending R0 write is lost and no partial write occurs after reset.
- rf_we is never high in EXC or IDLE.

## Configuration
- ALU_WB_OVF_TRAP_EN defined: overflow trapping behaves as described above.
- ALU_WB_OVF_TRAP_EN undefined:
  - ex_overflow is ignored and the result is written normally.
  - EXC state is not compiled.
  - exc_req is tied 0, exc_epc is tied 0, and exc_ack is unused.

## Structure
- Shared package alu_pkg holds:
  - ctrl code constants (CTRL_ADD … CTRL_ADDNF)
  - R0_ADDR = 0
  - the FSM state enum typedef
  - a helper predicate is_two_write(ctrl)
- One natural sub-module: alu_wb_hold. It is the capture register for ctrl, rd, result, r0, pc and wb_en, with a load enable and asynchronous reset.

## Test plan
- ADD, ctrl=1, rd=3, result=0x0005, overflow=0 -> next cycle rf_we=1, waddr=3, wdata=0x0005; ex_ready stays 1.
- MUL, ctrl=4, rd=2, result=0x5678, r0=0x1234 -> cycle N+1 writes reg2=0x5678, cycle N+2 writes reg0=0x1234; ex_ready=0 in N+1.
- DIV with rd=0, result=7, r0=1 -> N+1 rf_we=0; N+2 writes reg0=0x0001.
- SUB, ctrl=2, overflow=1, pc=0x0040, with TRAP_EN -> no write, exc_req=1, epc=0x0040, ex_ready=0. Hold exc_ack low 3 cycles and the state must hold; then ack -> IDLE. Without TRAP_EN, the same stimulus writes rd.
- Back-to-back ORI rd=1, ANDI rd=4, ctrl=5 (undefined) rd=6 -> writes reg1, then reg4, then no write; one op accepted per cycle.
- rst pulsed in cycle N+1 of a MUL -> no R0 write, all outputs at reset values, ex_ready=1 after release.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: definitions shared by the ALU writeback slice.
//   - ALU control codes and the register address that receives MUL/DIV side results
//   - encoding of the writeback sequencer states
//   - small decode predicates used by the sequencer
package alu_pkg;

    localparam int CTRL_W = 4;

    localparam logic [CTRL_W-1:0] CTRL_ADD   = 4'h1;
    localparam logic [CTRL_W-1:0] CTRL_SUB   = 4'h2;
    localparam logic [CTRL_W-1:0] CTRL_MUL   = 4'h4;
    localparam logic [CTRL_W-1:0] CTRL_DIV   = 4'h8;
    localparam logic [CTRL_W-1:0] CTRL_ANDI  = 4'hC;
    localparam logic [CTRL_W-1:0] CTRL_ORI   = 4'hE;
    localparam logic [CTRL_W-1:0] CTRL_ADDNF = 4'hF;

    // MUL/DIV side result (high product / remainder) always lands in R0.
    localparam int unsigned R0_ADDR = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WR_RD = 2'd1,
        ST_WR_R0 = 2'd2,
        ST_EXC   = 2'd3
    } wb_state_e;

    // Ops that produce a primary and a side result and so need two write cycles.
    function automatic logic is_two_write(input logic [CTRL_W-1:0] ctrl);
        return (ctrl == CTRL_MUL) || (ctrl == CTRL_DIV);
    endfunction

    // Ops that can raise a signed-overflow trap.
    function automatic logic is_add_sub(input logic [CTRL_W-1:0] ctrl);
        return (ctrl == CTRL_ADD) || (ctrl == CTRL_SUB);
    endfunction

    // Codes that write the register file; anything else is a no-write op.
    function automatic logic is_valid_ctrl(input logic [CTRL_W-1:0] ctrl);
        case (ctrl)
            CTRL_ADD, CTRL_SUB, CTRL_MUL, CTRL_DIV,
            CTRL_ANDI, CTRL_ORI, CTRL_ADDNF: return 1'b1;
            default:                         return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_writeback_if.sv
// alu_writeback_if: execute-stage result bus (valid/ready handshake).
//   master : execute stage, drives the offer and samples ex_ready
//   slave  : writeback sequencer, samples the offer and drives ex_ready
// Signals: ex_valid, ex_ready, ex_ctrl, ex_wb_en, ex_rd, ex_result, ex_r0,
//          ex_overflow, ex_pc.
interface alu_writeback_if #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4
);
    logic              ex_valid;
    logic              ex_ready;
    logic [3:0]        ex_ctrl;
    logic              ex_wb_en;
    logic [REG_AW-1:0] ex_rd;
    logic [DATA_W-1:0] ex_result;
    logic [DATA_W-1:0] ex_r0;
    logic              ex_overflow;
    logic [DATA_W-1:0] ex_pc;

    modport master (
        output ex_valid, ex_ctrl, ex_wb_en, ex_rd, ex_result, ex_r0, ex_overflow, ex_pc,
        input  ex_ready
    );

    modport slave (
        input  ex_valid, ex_ctrl, ex_wb_en, ex_rd, ex_result, ex_r0, ex_overflow, ex_pc,
        output ex_ready
    );
endinterface

// File: rtl/alu_wb_hold.sv
// alu_wb_hold: capture register for an accepted ALU result.
//   clk, rst      : clock, asynchronous active-high reset (clears all fields)
//   load          : capture the d_* fields on this edge
//   d_* / q_*     : ctrl, wb_en, rd, result, r0, pc in / registered out
module alu_wb_hold #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [3:0]        d_ctrl,
    input  logic              d_wb_en,
    input  logic [REG_AW-1:0] d_rd,
    input  logic [DATA_W-1:0] d_result,
    input  logic [DATA_W-1:0] d_r0,
    input  logic [DATA_W-1:0] d_pc,
    output logic [3:0]        q_ctrl,
    output logic              q_wb_en,
    output logic [REG_AW-1:0] q_rd,
    output logic [DATA_W-1:0] q_result,
    output logic [DATA_W-1:0] q_r0,
    output logic [DATA_W-1:0] q_pc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_ctrl   <= '0;
            q_wb_en  <= 1'b0;
            q_rd     <= '0;
            q_result <= '0;
            q_r0     <= '0;
            q_pc     <= '0;
        end else if (load) begin
            q_ctrl   <= d_ctrl;
            q_wb_en  <= d_wb_en;
            q_rd     <= d_rd;
            q_result <= d_result;
            q_r0     <= d_r0;
            q_pc     <= d_pc;
        end
    end

endmodule

// File: rtl/alu_writeback.sv
// alu_writeback: serialises captured ALU results onto the single
// register-file write port; MUL/DIV take two write cycles (rd, then R0).
// Optional feature macro: ALU_WB_OVF_TRAP_EN -- when defined, a signed
// overflow on ADD/SUB suppresses the write and raises exc_req until exc_ack.
//   clk, rst         : clock, asynchronous active-high reset
//   ex               : result bus (slave side, valid/ready)
//   rf_we/waddr/wdata: register-file write port
//   exc_req/exc_epc  : overflow trap request and PC of the trapping op
//   exc_ack          : trap accepted by the control unit
module alu_writeback
    import alu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4
) (
    input  logic              clk,
    input  logic              rst,
    alu_writeback_if.slave    ex,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              exc_req,
    output logic [DATA_W-1:0] exc_epc,
    input  logic              exc_ack
);

    localparam logic [1:0] IDLE  = ST_IDLE;
    localparam logic [1:0] WR_RD = ST_WR_RD;
    localparam logic [1:0] WR_R0 = ST_WR_R0;
`ifdef ALU_WB_OVF_TRAP_EN
    localparam logic [1:0] EXC   = ST_EXC;
`endif

    logic [1:0]        state_reg;
    logic [1:0]        state_next;
    logic              accept;
    logic              ready;

    logic [3:0]        hold_ctrl;
    logic              hold_wb_en;
    logic [REG_AW-1:0] hold_rd;
    logic [DATA_W-1:0] hold_result;
    logic [DATA_W-1:0] hold_r0;
    logic [DATA_W-1:0] hold_pc;

    assign accept      = ex.ex_valid & ready;
    assign ex.ex_ready = ready;

    alu_wb_hold #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_hold (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .d_ctrl   (ex.ex_ctrl),
        .d_wb_en  (ex.ex_wb_en),
        .d_rd     (ex.ex_rd),
        .d_result (ex.ex_result),
        .d_r0     (ex.ex_r0),
        .d_pc     (ex.ex_pc),
        .q_ctrl   (hold_ctrl),
        .q_wb_en  (hold_wb_en),
        .q_rd     (hold_rd),
        .q_result (hold_result),
        .q_r0     (hold_r0),
        .q_pc     (hold_pc)
    );

    // The hold register is free to reload whenever the current cycle is its
    // last use: single-write WR_RD and WR_R0 both release it at the edge.
    always_comb begin
        ready = 1'b1;
        if (rst) begin
            ready = 1'b0;
        end else if (state_reg == WR_RD && is_two_write(hold_ctrl)) begin
            ready = 1'b0;
`ifdef ALU_WB_OVF_TRAP_EN
        end else if (state_reg == EXC) begin
            ready = 1'b0;
`endif
        end
    end

    always_comb begin
        state_next = state_reg;
        if (accept) begin
            if (is_valid_ctrl(ex.ex_ctrl) && ex.ex_wb_en) begin
                state_next = WR_RD;
            end else begin
                state_next = IDLE;
            end
`ifdef ALU_WB_OVF_TRAP_EN
            // Trap takes priority over any write of the offending op.
            if (ex.ex_overflow && is_add_sub(ex.ex_ctrl)) begin
                state_next = EXC;
            end
`endif
        end else begin
            case (state_reg)
                WR_RD:   state_next = is_two_write(hold_ctrl) ? WR_R0 : IDLE;
                WR_R0:   state_next = IDLE;
`ifdef ALU_WB_OVF_TRAP_EN
                EXC:     state_next = exc_ack ? IDLE : EXC;
`endif
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Write port is decoded from state and hold register only, so nothing on
    // the ex bus reaches rf_* combinationally.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = hold_rd;
        rf_wdata = hold_result;
        case (state_reg)
            WR_RD: begin
                // MUL/DIV targeting R0: the side result owns R0, skip the primary.
                rf_we = hold_wb_en &&
                        !(is_two_write(hold_ctrl) && hold_rd == REG_AW'(R0_ADDR));
            end
            WR_R0: begin
                rf_we    = 1'b1;
                rf_waddr = REG_AW'(R0_ADDR);
                rf_wdata = hold_r0;
            end
            default: begin
                rf_we = 1'b0;
            end
        endcase
    end

`ifdef ALU_WB_OVF_TRAP_EN
    // hold_pc cannot change in EXC because ex_ready is low there.
    assign exc_req = (state_reg == EXC);
    assign exc_epc = hold_pc;
`else
    logic unused_trap_sigs;
    assign exc_req          = 1'b0;
    assign exc_epc          = '0;
    assign unused_trap_sigs = ^{exc_ack, ex.ex_overflow, hold_pc};
`endif

endmodule

// File: tb/tb_alu_writeback.sv
module tb_alu_writeback;

    localparam int DATA_W = 16;
    localparam int REG_AW = 4;

    logic              clk;
    logic              rst;
    logic              rf_we;
    logic [REG_AW-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              exc_req;
    logic [DATA_W-1:0] exc_epc;
    logic              exc_ack;

    int checks = 0;
    int errors = 0;

    alu_writeback_if #(.DATA_W(DATA_W), .REG_AW(REG_AW)) ex_bus ();

    alu_writeback #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ex       (ex_bus),
        .rf_we    (rf_we),
        .rf_waddr (rf_waddr),
        .rf_wdata (rf_wdata),
        .exc_req  (exc_req),
        .exc_epc  (exc_epc),
        .exc_ack  (exc_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic offer(input logic [3:0] ctrl, input logic wb_en, input logic [3:0] rd,
                         input logic [15:0] result, input logic [15:0] r0,
                         input logic ovf, input logic [15:0] pc);
        ex_bus.ex_valid    = 1'b1;
        ex_bus.ex_ctrl     = ctrl;
        ex_bus.ex_wb_en    = wb_en;
        ex_bus.ex_rd       = rd;
        ex_bus.ex_result   = result;
        ex_bus.ex_r0       = r0;
        ex_bus.ex_overflow = ovf;
        ex_bus.ex_pc       = pc;
        $display("txn ctrl=%h wb_en=%0d rd=%0d result=%h r0=%h ovf=%0d pc=%h",
                 ctrl, wb_en, rd, result, r0, ovf, pc);
    endtask

    task automatic chk_wr(input string tag, input logic we, input logic [3:0] addr,
                          input logic [15:0] data);
        chk({tag, ".we"}, 32'(rf_we), 32'(we));
        if (we) begin
            chk({tag, ".waddr"}, 32'(rf_waddr), 32'(addr));
            chk({tag, ".wdata"}, 32'(rf_wdata), 32'(data));
        end
    endtask

    initial begin
        rst                = 1'b1;
        exc_ack            = 1'b0;
        ex_bus.ex_valid    = 1'b0;
        ex_bus.ex_ctrl     = 4'h0;
        ex_bus.ex_wb_en    = 1'b0;
        ex_bus.ex_rd       = 4'h0;
        ex_bus.ex_result   = 16'h0;
        ex_bus.ex_r0       = 16'h0;
        ex_bus.ex_overflow = 1'b0;
        ex_bus.ex_pc       = 16'h0;

        // Reset values
        tick();
        tick();
        chk("rst.ready",  32'(ex_bus.ex_ready), 32'd0);
        chk("rst.we",     32'(rf_we),    32'd0);
        chk("rst.waddr",  32'(rf_waddr), 32'd0);
        chk("rst.wdata",  32'(rf_wdata), 32'd0);
        chk("rst.excreq", 32'(exc_req),  32'd0);
        chk("rst.epc",    32'(exc_epc),  32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst.ready", 32'(ex_bus.ex_ready), 32'd1);
        tick();

        // ADD rd=3 -> single write next cycle, ready stays high
        offer(4'h1, 1'b1, 4'd3, 16'h0005, 16'h0000, 1'b0, 16'h0010);
        tick();
        ex_bus.ex_valid = 1'b0;
        chk_wr("add", 1'b1, 4'd3, 16'h0005);
        chk("add.ready", 32'(ex_bus.ex_ready), 32'd1);
        tick();
        chk("add.idle_we", 32'(rf_we), 32'd0);

        // MUL rd=2 -> reg2=0x5678, then reg0=0x1234; ready low in N+1
        offer(4'h4, 1'b1, 4'd2, 16'h5678, 16'h1234, 1'b0, 16'h0014);
        tick();
        ex_bus.ex_valid = 1'b0;
        chk_wr("mul.rd", 1'b1, 4'd2, 16'h5678);
        chk("mul.ready_n1", 32'(ex_bus.ex_ready), 32'd0);
        tick();
        chk_wr("mul.r0", 1'b1, 4'd0, 16'h1234);
        chk("mul.ready_n2", 32'(ex_bus.ex_ready), 32'd1);
        tick();
        chk("mul.idle_we", 32'(rf_we), 32'd0);

        // DIV rd=0 -> primary write suppressed, R0 gets remainder
        offer(4'h8, 1'b1, 4'd0, 16'h0007, 16'h0001, 1'b0, 16'h0018);
        tick();
        ex_bus.ex_valid = 1'b0;
        chk("div0.we_n1", 32'(rf_we), 32'd0);
        chk("div0.ready_n1", 32'(ex_bus.ex_ready), 32'd0);
        tick();
        chk_wr("div0.r0", 1'b1, 4'd0, 16'h0001);
        tick();

        // SUB with overflow
        offer(4'h2, 1'b1, 4'd5, 16'h8000, 16'h0000, 1'b1, 16'h0040);
        tick();
        ex_bus.ex_valid = 1'b0;
`ifdef ALU_WB_OVF_TRAP_EN
        chk("trap.we",     32'(rf_we),    32'd0);
        chk("trap.excreq", 32'(exc_req),  32'd1);
        chk("trap.epc",    32'(exc_epc),  32'h0040);
        chk("trap.ready",  32'(ex_bus.ex_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("trap.hold_req",   32'(exc_req), 32'd1);
            chk("trap.hold_epc",   32'(exc_epc), 32'h0040);
            chk("trap.hold_ready", 32'(ex_bus.ex_ready), 32'd0);
            chk("trap.hold_we",    32'(rf_we), 32'd0);
        end
        exc_ack = 1'b1;
        tick();
        exc_ack = 1'b0;
        chk("trap.ack_req",   32'(exc_req), 32'd0);
        chk("trap.ack_ready", 32'(ex_bus.ex_ready), 32'd1);
        chk("trap.ack_we",    32'(rf_we), 32'd0);
`else
        chk_wr("ovf_notrap", 1'b1, 4'd5, 16'h8000);
        chk("ovf_notrap.excreq", 32'(exc_req), 32'd0);
        chk("ovf_notrap.epc",    32'(exc_epc), 32'd0);
        chk("ovf_notrap.ready",  32'(ex_bus.ex_ready), 32'd1);
        tick();
`endif

        // Back-to-back ORI rd=1, ANDI rd=4, undefined ctrl=5 rd=6
        offer(4'hE, 1'b1, 4'd1, 16'h00F1, 16'h0000, 1'b0, 16'h0044);
        tick();
        chk_wr("b2b.ori", 1'b1, 4'd1, 16'h00F1);
        chk("b2b.ready1", 32'(ex_bus.ex_ready), 32'd1);
        offer(4'hC, 1'b1, 4'd4, 16'h0004, 16'h0000, 1'b0, 16'h0046);
        tick();
        chk_wr("b2b.andi", 1'b1, 4'd4, 16'h0004);
        chk("b2b.ready2", 32'(ex_bus.ex_ready), 32'd1);
        offer(4'h5, 1'b1, 4'd6, 16'h0066, 16'h0000, 1'b0, 16'h0048);
        tick();
        ex_bus.ex_valid = 1'b0;
        chk("b2b.undef_we", 32'(rf_we), 32'd0);
        tick();

        // MUL with wb_en=0 is dropped
        offer(4'h4, 1'b0, 4'd7, 16'hAAAA, 16'hBBBB, 1'b0, 16'h004A);
        tick();
        ex_bus.ex_valid = 1'b0;
        chk("mul_nowb.we", 32'(rf_we), 32'd0);
        chk("mul_nowb.ready", 32'(ex_bus.ex_ready), 32'd1);
        tick();

        // New op accepted during WR_R0 of a MUL
        offer(4'h4, 1'b1, 4'd7, 16'h000A, 16'h000B, 1'b0, 16'h004C);
        tick();
        ex_bus.ex_valid = 1'b0;
        chk_wr("mulov.rd", 1'b1, 4'd7, 16'h000A);
        tick();
        chk_wr("mulov.r0", 1'b1, 4'd0, 16'h000B);
        chk("mulov.ready_r0", 32'(ex_bus.ex_ready), 32'd1);
        offer(4'h1, 1'b1, 4'd9, 16'h0099, 16'h0000, 1'b0, 16'h004E);
        tick();
        ex_bus.ex_valid = 1'b0;
        chk_wr("mulov.add", 1'b1, 4'd9, 16'h0099);
        tick();

        // Reset pulsed in N+1 of a MUL aborts the R0 write
        offer(4'h4, 1'b1, 4'd3, 16'h1111, 16'h2222, 1'b0, 16'h0050);
        tick();
        ex_bus.ex_valid = 1'b0;
        chk_wr("rstmul.rd", 1'b1, 4'd3, 16'h1111);
        rst = 1'b1;
        #1;
        chk("rstmul.we",     32'(rf_we),    32'd0);
        chk("rstmul.waddr",  32'(rf_waddr), 32'd0);
        chk("rstmul.wdata",  32'(rf_wdata), 32'd0);
        chk("rstmul.excreq", 32'(exc_req),  32'd0);
        chk("rstmul.ready",  32'(ex_bus.ex_ready), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("rstmul.ready_rel", 32'(ex_bus.ex_ready), 32'd1);
        chk("rstmul.we_rel",    32'(rf_we), 32'd0);
        tick();
        chk("rstmul.no_r0_we",  32'(rf_we), 32'd0);
        chk("rstmul.waddr_rel", 32'(rf_waddr), 32'd0);
        chk("rstmul.wdata_rel", 32'(rf_wdata), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
